// File: rtl/graphics_compositor_if.sv
// Pixel-side bundle of the compositor: layer/palette inputs from the layer generators,
// VGA pins, beam position and game ticks back out.
interface graphics_compositor_if #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned CONV       = 0
);
  logic [NUM_LAYERS-1:0]   i_layer;
  logic [6*NUM_LAYERS-1:0] i_palette;
  logic [5:0]              i_bg_color;
  logic [NUM_LAYERS-1:0]   i_collide_mask_a;
  logic [NUM_LAYERS-1:0]   i_collide_mask_b;
  logic                    i_game_start_pulse;
  logic                    o_hsync;
  logic                    o_vsync;
  logic [1:0]              o_red;
  logic [1:0]              o_green;
  logic [1:0]              o_blue;
  logic [9-CONV:0]         o_hpos;
  logic [9-CONV:0]         o_vpos;
  logic                    o_frame_tick;
  logic                    o_game_tick;
  logic                    o_game_tick_r;
  logic                    o_row_tick;
  logic                    o_collision;
  logic                    o_collision_pulse;

  modport master (
    output i_layer, i_palette, i_bg_color, i_collide_mask_a, i_collide_mask_b,
           i_game_start_pulse,
    input  o_hsync, o_vsync, o_red, o_green, o_blue, o_hpos, o_vpos, o_frame_tick,
           o_game_tick, o_game_tick_r, o_row_tick, o_collision, o_collision_pulse
  );

  modport slave (
    input  i_layer, i_palette, i_bg_color, i_collide_mask_a, i_collide_mask_b,
           i_game_start_pulse,
    output o_hsync, o_vsync, o_red, o_green, o_blue, o_hpos, o_vpos, o_frame_tick,
           o_game_tick, o_game_tick_r, o_row_tick, o_collision, o_collision_pulse
  );
endinterface

// File: rtl/graphics_compositor.sv
// VGA back end: timing counters, 2-stage priority compositor with per-layer palette,
// frame/game/row ticks and masked sticky collision detection.
module graphics_compositor #(
  parameter int unsigned H_DISPLAY  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_DISPLAY  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned SYNC_NEG   = 1,
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned TICK_DIV   = 3,
  parameter int unsigned ROW_BIT    = 5,
  parameter int unsigned CONV       = 0
) (
  input logic                   clk,
  input logic                   rst,
  graphics_compositor_if.slave  bus
);
  localparam int unsigned HTotal   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HSyncBeg = H_DISPLAY + H_FRONT;
  localparam int unsigned VSyncBeg = V_DISPLAY + V_FRONT;
  localparam int unsigned WinW     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int unsigned DivW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic        SyncIdle = 1'(SYNC_NEG);

  logic [9:0]      hpos_q, vpos_q;
  logic            h_end, v_end;
  logic            hs_raw, vs_raw, disp_raw;
  logic [WinW-1:0] win_d, win_q;
  logic            any_q, de_q, hs1_q, vs1_q;
  logic [5:0]      rgb_d, rgb_q;
  logic            hsync_q, vsync_q;
  logic            frame_q, game_tick, game_r_q;
  logic [DivW-1:0] div_q;
  logic            vbit_q, row_q;
  logic [NUM_LAYERS-1:0] a_hit, b_hit;
  logic            cross_hit, hit, coll_d, coll_q, pulse_q;

  assign h_end    = (hpos_q == 10'(HTotal - 1));
  assign v_end    = (vpos_q == 10'(VTotal - 1));
  assign hs_raw   = ({1'b0, hpos_q} >= 11'(HSyncBeg)) && ({1'b0, hpos_q} < 11'(HSyncBeg + H_SYNC));
  assign vs_raw   = ({1'b0, vpos_q} >= 11'(VSyncBeg)) && ({1'b0, vpos_q} < 11'(VSyncBeg + V_SYNC));
  assign disp_raw = ({1'b0, hpos_q} < 11'(H_DISPLAY)) && ({1'b0, vpos_q} < 11'(V_DISPLAY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hpos_q <= '0;
      vpos_q <= '0;
    end else begin
      hpos_q <= h_end ? 10'd0 : hpos_q + 10'd1;
      if (h_end) vpos_q <= v_end ? 10'd0 : vpos_q + 10'd1;
    end
  end

  // Highest set bit wins: later iterations overwrite lower indices.
  always_comb begin
    win_d = '0;
    for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
      if (bus.i_layer[k]) win_d = WinW'(k);
    end
  end

  always_comb begin
    rgb_d = '0;
    if (de_q) rgb_d = any_q ? bus.i_palette[int'(win_q) * 6 +: 6] : bus.i_bg_color;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q   <= '0;
      any_q   <= 1'b0;
      de_q    <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      rgb_q   <= '0;
      hsync_q <= SyncIdle;
      vsync_q <= SyncIdle;
    end else begin
      win_q   <= win_d;
      any_q   <= |bus.i_layer;
      de_q    <= disp_raw;
      hs1_q   <= hs_raw;
      vs1_q   <= vs_raw;
      rgb_q   <= rgb_d;
      hsync_q <= hs1_q ^ SyncIdle;
      vsync_q <= vs1_q ^ SyncIdle;
    end
  end

  assign game_tick = frame_q && (div_q == DivW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q  <= 1'b0;
      div_q    <= '0;
      game_r_q <= 1'b0;
      vbit_q   <= 1'b0;
      row_q    <= 1'b0;
    end else begin
      frame_q  <= h_end && v_end;
      if (frame_q) div_q <= game_tick ? '0 : div_q + DivW'(1);
      game_r_q <= game_tick;
      vbit_q   <= vpos_q[ROW_BIT];
      row_q    <= vpos_q[ROW_BIT] & ~vbit_q;
    end
  end

  assign a_hit = bus.i_layer & bus.i_collide_mask_a;
  assign b_hit = bus.i_layer & bus.i_collide_mask_b;

  // A layer in both masks only collides when some other layer is lit as well.
  always_comb begin
    cross_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      for (int unsigned j = 0; j < NUM_LAYERS; j++) begin
        if (i != j && a_hit[i] && b_hit[j]) cross_hit = 1'b1;
      end
    end
    hit = disp_raw && (cross_hit || ((|(a_hit & b_hit)) &&
          ((bus.i_layer & (bus.i_layer - NUM_LAYERS'(1))) != '0)));
    coll_d = coll_q;
    if (bus.i_game_start_pulse) coll_d = 1'b0;
    else if (hit)               coll_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      coll_q  <= coll_d;
      pulse_q <= coll_d & ~coll_q;
    end
  end

  assign bus.o_hpos            = hpos_q[9:CONV];
  assign bus.o_vpos            = vpos_q[9:CONV];
  assign bus.o_hsync           = hsync_q;
  assign bus.o_vsync           = vsync_q;
  assign bus.o_red             = rgb_q[5:4];
  assign bus.o_green           = rgb_q[3:2];
  assign bus.o_blue            = rgb_q[1:0];
  assign bus.o_frame_tick      = frame_q;
  assign bus.o_game_tick       = game_tick;
  assign bus.o_game_tick_r     = game_r_q;
  assign bus.o_row_tick        = row_q;
  assign bus.o_collision       = coll_q;
  assign bus.o_collision_pulse = pulse_q;
endmodule

// File: tb/tb_graphics_compositor.sv
// Randomized bench for graphics_compositor on a tiny 12x7 raster, checked against a
// cycle-indexed model of beam position, pixel pipeline, ticks and collision flag.
module tb_graphics_compositor;
  localparam int HT = 12, VT = 7, FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  graphics_compositor_if #(.NUM_LAYERS(4), .CONV(0)) bus ();
  graphics_compositor_if #(.NUM_LAYERS(4), .CONV(0)) bus1 ();

  assign bus1.i_layer            = bus.i_layer;
  assign bus1.i_palette          = bus.i_palette;
  assign bus1.i_bg_color         = bus.i_bg_color;
  assign bus1.i_collide_mask_a   = bus.i_collide_mask_a;
  assign bus1.i_collide_mask_b   = bus.i_collide_mask_b;
  assign bus1.i_game_start_pulse = bus.i_game_start_pulse;

  graphics_compositor #(
    .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_NEG(1), .NUM_LAYERS(4), .TICK_DIV(3), .ROW_BIT(1), .CONV(0)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  graphics_compositor #(
    .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_NEG(1), .NUM_LAYERS(4), .TICK_DIV(1), .ROW_BIT(1), .CONV(0)
  ) dut_div1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  logic [3:0]  lay_h [0:1023];
  logic [23:0] pal_h [0:1023];
  logic [5:0]  bg_h  [0:1023];
  logic [3:0]  ma_h  [0:1023];
  logic [3:0]  mb_h  [0:1023];
  logic        st_h  [0:1023];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int hx(int m); return m % HT; endfunction
  function automatic int vy(int m); return (m / HT) % VT; endfunction
  function automatic bit disp(int m); return hx(m) < 8 && vy(m) < 4; endfunction
  function automatic bit frame(int m); return m > 0 && m % FRAME == 0; endfunction
  function automatic bit game(int m); return frame(m) && (m / FRAME) % 3 == 0; endfunction
  function automatic bit rowbit(int m); return ((vy(m) / 2) % 2) == 1; endfunction

  function automatic logic [5:0] colour(int m, logic [3:0] lay, logic [23:0] pal,
                                        logic [5:0] bg);
    if (!disp(m)) return 6'd0;
    for (int k = 3; k >= 0; k--) if (lay[k]) return pal[6*k +: 6];
    return bg;
  endfunction

  function automatic bit hitm(int m);
    logic [3:0] a, b;
    bit x = 0;
    a = lay_h[m] & ma_h[m];
    b = lay_h[m] & mb_h[m];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (i != j && a[i] && b[j]) x = 1;
    if ((a & b) != 0 && $countones(lay_h[m]) >= 2) x = 1;
    return disp(m) && x;
  endfunction

  task automatic drive(input int m, input bit directed);
    lay_h[m] = 4'($urandom);
    pal_h[m] = 24'($urandom);
    bg_h[m]  = 6'($urandom);
    ma_h[m]  = 4'($urandom);
    mb_h[m]  = 4'($urandom);
    st_h[m]  = ($urandom_range(0, 15) == 0);
    if (directed) begin
      if (m <= 5) st_h[m] = 1'b1;
      if (m >= 2 && m <= 6) begin
        pal_h[m][17:12] = 6'b110000;
        pal_h[m][11:6]  = 6'b001100;
        bg_h[m]         = 6'b000011;
      end
      if (m >= 2 && m <= 4) lay_h[m] = 4'b0110;
      if (m == 5 || m == 7 || m == 9 || m == 11) lay_h[m] = 4'b0000;
      if (m == 6 || m == 8 || m == 10) begin
        lay_h[m] = 4'b0110;
        ma_h[m]  = 4'b0010;
        mb_h[m]  = 4'b0100;
      end
      if (m >= 6 && m <= 11) st_h[m] = (m == 8);
    end
    bus.i_layer            = lay_h[m];
    bus.i_palette          = pal_h[m];
    bus.i_bg_color         = bg_h[m];
    bus.i_collide_mask_a   = ma_h[m];
    bus.i_collide_mask_b   = mb_h[m];
    bus.i_game_start_pulse = st_h[m];
  endtask

  // Called on a negedge right after reset release; leaves off on a negedge.
  task automatic run_phase(input int cycles, input bit directed);
    bit ecoll = 0, epulse = 0, nc;
    logic [5:0] ergb;
    for (int n = 0; n < cycles; n++) begin
      if (n > 0) begin
        nc = st_h[n-1] ? 1'b0 : (hitm(n-1) ? 1'b1 : ecoll);
        epulse = nc && !ecoll;
        ecoll = nc;
      end
      ergb = (n < 2) ? 6'd0 : colour(n-2, lay_h[n-2], pal_h[n-1], bg_h[n-1]);
      check("hpos", 32'(bus.o_hpos), 32'(hx(n)));
      check("vpos", 32'(bus.o_vpos), 32'(vy(n)));
      check("rgb", 32'({bus.o_red, bus.o_green, bus.o_blue}), 32'(ergb));
      check("hsync", 32'(bus.o_hsync), 32'((n < 2) ? 1 : !(hx(n-2) >= 9 && hx(n-2) < 11)));
      check("vsync", 32'(bus.o_vsync), 32'((n < 2) ? 1 : (vy(n-2) != 5)));
      check("frame_tick", 32'(bus.o_frame_tick), 32'(frame(n)));
      check("game_tick", 32'(bus.o_game_tick), 32'(game(n)));
      check("game_tick_r", 32'(bus.o_game_tick_r), 32'(n >= 1 && game(n-1)));
      check("row_tick", 32'(bus.o_row_tick), 32'(n >= 2 && rowbit(n-1) && !rowbit(n-2)));
      check("collision", 32'(bus.o_collision), 32'(ecoll));
      check("collision_pulse", 32'(bus.o_collision_pulse), 32'(epulse));
      check("div1_game_tick", 32'(bus1.o_game_tick), 32'(frame(n)));
      if (directed) begin
        if (n == 6) check("dir_palette2", 32'({bus.o_red, bus.o_green, bus.o_blue}), 32'h30);
        if (n == 7) begin
          check("dir_bg", 32'({bus.o_red, bus.o_green, bus.o_blue}), 32'h03);
          check("dir_coll_set", 32'({bus.o_collision, bus.o_collision_pulse}), 32'h3);
        end
        if (n == 8) check("dir_coll_hold", 32'({bus.o_collision, bus.o_collision_pulse}), 32'h2);
        if (n == 9) check("dir_start_wins", 32'(bus.o_collision), 32'h0);
        if (n == 11) begin
          check("dir_blank_nohit", 32'(bus.o_collision), 32'h0);
          check("dir_hsync_low", 32'(bus.o_hsync), 32'h0);
        end
      end
      drive(n, directed);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rgb"}, 32'({bus.o_red, bus.o_green, bus.o_blue}), 32'h0);
    check({tag, "_sync"}, 32'({bus.o_hsync, bus.o_vsync}), 32'h3);
    check({tag, "_pos"}, 32'({bus.o_hpos, bus.o_vpos}), 32'h0);
    check({tag, "_ticks"}, 32'({bus.o_frame_tick, bus.o_game_tick, bus.o_game_tick_r,
                                 bus.o_row_tick}), 32'h0);
    check({tag, "_coll"}, 32'({bus.o_collision, bus.o_collision_pulse}), 32'h0);
  endtask

  initial begin
    bus.i_layer            = '0;
    bus.i_palette          = '0;
    bus.i_bg_color         = '0;
    bus.i_collide_mask_a   = '0;
    bus.i_collide_mask_b   = '0;
    bus.i_game_start_pulse = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    run_phase(800, 1'b1);
    // Assert reset between edges: outputs must drop without a clock edge.
    #2 rst = 1'b1;
    #1 check_reset_state("async_reset");
    @(negedge clk);
    rst = 1'b0;
    run_phase(200, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
